// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset main control FSM: sequences the shared ALU/memory datapath per instruction.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8,
  parameter logic [5:0] OP_SLTI  = 6'd10,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] instr_cnt_o
);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_RWB   = 4'd7,
    S_EXI   = 4'd8,
    S_IWB   = 4'd9,
    S_BR    = 4'd10,
    S_JMP   = 4'd11
  } state_t;

  state_t state, next_state;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = S_IF;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (state)
      S_IF: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        // PC+4 only on the ready cycle so a stalled fetch does not advance PC twice
        pc_write   = mem_ready_i;
        next_state = mem_ready_i ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:     next_state = S_MADDR;
          OP_RTYPE:         next_state = S_EXR;
          OP_ADDI, OP_SLTI: next_state = S_EXI;
          OP_BEQ:           next_state = S_BR;
          OP_J:             next_state = S_JMP;
          default: begin
            illegal    = 1'b1;
            next_state = S_IF;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode_i == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        i_or_d     = 1'b1;
        mem_read   = 1'b1;
        next_state = mem_ready_i ? S_MWB : S_MRD;
      end
      S_MWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MWR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready_i ? S_IF : S_MWR;
      end
      S_EXR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = S_RWB;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXI: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state = S_IWB;
      end
      S_IWB: reg_write = 1'b1;
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: next_state = S_IF;
    endcase
  end

  assign pc_write_o      = ~rst_i & pc_write;
  assign pc_write_cond_o = ~rst_i & pc_write_cond;
  assign i_or_d_o        = ~rst_i & i_or_d;
  assign mem_read_o      = ~rst_i & mem_read;
  assign mem_write_o     = ~rst_i & mem_write;
  assign ir_write_o      = ~rst_i & ir_write;
  assign mem_to_reg_o    = ~rst_i & mem_to_reg;
  assign reg_dst_o       = ~rst_i & reg_dst;
  assign reg_write_o     = ~rst_i & reg_write;
  assign alu_src_a_o     = ~rst_i & alu_src_a;
  assign alu_src_b_o     = rst_i ? 2'b00 : alu_src_b;
  assign alu_op_o        = rst_i ? 3'b000 : alu_op;
  assign pc_source_o     = rst_i ? 2'b00 : pc_source;
  assign illegal_o       = ~rst_i & illegal;
  assign state_o         = state;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic        retire;
  logic [31:0] instr_cnt;

  assign retire = (state == S_MWB) || (state == S_RWB) || (state == S_IWB) ||
                  (state == S_BR)  || (state == S_JMP) ||
                  ((state == S_MWR) && mem_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)       instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 32'd1;
  end

  assign instr_cnt_o = instr_cnt;
`else
  assign instr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected state/control timelines built from opcode class and wait counts.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  opcode_i;
  logic        mem_ready_i;
  logic        pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic        mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0]  alu_src_b_o, pc_source_o;
  logic [2:0]  alu_op_o;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt_o;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .illegal_o(illegal_o), .state_o(state_o),
    .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       ready;
  } step_t;

  ctrl_t dut_ctrl;
  assign dut_ctrl = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
                     mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                     pc_source_o, illegal_o};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] model_cnt = '0;
  step_t       plan[$];

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};
  endfunction

  // Control word each state must present, straight from the state descriptions.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    ctrl_t c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = rdy; end
      4'd1:  begin c.alu_src_b = 2'b11; c.illegal = !is_legal(op); end
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.i_or_d = 1; c.mem_read = 1; end
      4'd4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      4'd5:  begin c.i_or_d = 1; c.mem_write = 1; end
      4'd6:  begin c.alu_src_a = 1; c.alu_op = 3'b010; end
      4'd7:  begin c.reg_dst = 1; c.reg_write = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 6'd10) ? 3'b011 : 3'b000; end
      4'd9:  c.reg_write = 1;
      4'd10: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      4'd11: begin c.pc_write = 1; c.pc_source = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st = st;
    s.ready = rdy;
    plan.push_back(s);
  endtask

  task automatic build_plan(input logic [5:0] op, input int unsigned w_if, input int unsigned w_mem);
    plan.delete();
    repeat (w_if) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(0, 1)));
    if (is_legal(op)) begin
      case (op)
        6'd35: begin
          push(4'd2, 1'($urandom_range(0, 1)));
          repeat (w_mem) push(4'd3, 1'b0);
          push(4'd3, 1'b1);
          push(4'd4, 1'($urandom_range(0, 1)));
        end
        6'd43: begin
          push(4'd2, 1'($urandom_range(0, 1)));
          repeat (w_mem) push(4'd5, 1'b0);
          push(4'd5, 1'b1);
        end
        6'd0:        begin push(4'd6, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1))); end
        6'd8, 6'd10: begin push(4'd8, 1'($urandom_range(0, 1))); push(4'd9, 1'($urandom_range(0, 1))); end
        6'd4:        push(4'd10, 1'($urandom_range(0, 1)));
        default:     push(4'd11, 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    return model_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Entered and left at posedge+1; abort_st >= 0 asserts reset on the first cycle in that state.
  task automatic run_instr(input string name, input logic [5:0] op, input int unsigned w_if,
                           input int unsigned w_mem, input int abort_st);
    build_plan(op, w_if, w_mem);
    foreach (plan[i]) begin
      opcode_i    = op;
      mem_ready_i = plan[i].ready;
      if (abort_st >= 0 && int'(plan[i].st) == abort_st) begin
        rst_i = 1'b1;
        #4;
        n_cmp++;
        if (state_o !== plan[i].st) begin
          n_bad++;
          $display("FAIL %s abort-state: got %0d want %0d", name, state_o, plan[i].st);
        end
        n_cmp++;
        if (dut_ctrl !== ctrl_t'(0)) begin
          n_bad++;
          $display("FAIL %s ctrl-in-reset: got %h want 0", name, dut_ctrl);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_cnt = '0;
        n_cmp++;
        if (state_o !== 4'd0) begin
          n_bad++;
          $display("FAIL %s state-after-reset: got %0d want 0", name, state_o);
        end
        return;
      end
      #4;
      n_cmp++;
      if (state_o !== plan[i].st) begin
        n_bad++;
        $display("FAIL %s step%0d state: got %0d want %0d", name, i, state_o, plan[i].st);
      end
      n_cmp++;
      if (dut_ctrl !== exp_ctrl(plan[i].st, op, plan[i].ready)) begin
        n_bad++;
        $display("FAIL %s step%0d st%0d ctrl: got %h want %h", name, i, plan[i].st, dut_ctrl,
                 exp_ctrl(plan[i].st, op, plan[i].ready));
      end
      n_cmp++;
      if (instr_cnt_o !== exp_cnt()) begin
        n_bad++;
        $display("FAIL %s step%0d instr_cnt: got %0d want %0d", name, i, instr_cnt_o, exp_cnt());
      end
      @(posedge clk_i);
      #1;
    end
    if (is_legal(op)) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    opcode_i = 6'd0;
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #5;
    n_cmp++;
    if (dut_ctrl !== ctrl_t'(0)) begin
      n_bad++;
      $display("FAIL reset ctrl: got %h want 0", dut_ctrl);
    end
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset state: got %0d want 0", state_o);
    end
    n_cmp++;
    if (instr_cnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset instr_cnt: got %0d want 0", instr_cnt_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_cnt = '0;
  endtask

  task automatic test_rtype();
    run_instr("rtype", 6'd0, 0, 0, -1);
    run_instr("addi", 6'd8, 0, 0, -1);
    run_instr("slti", 6'd10, 0, 0, -1);
  endtask

  task automatic test_mem_wait();
    run_instr("lw_wait2", 6'd35, 0, 2, -1);
    run_instr("sw_wait1", 6'd43, 0, 1, -1);
  endtask

  task automatic test_if_stall();
    run_instr("if_stall3", 6'd0, 3, 0, -1);
  endtask

  task automatic test_branch_jump();
    run_instr("beq", 6'd4, 0, 0, -1);
    run_instr("j", 6'd2, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal63", 6'd63, 0, 0, -1);
    run_instr("after_illegal", 6'd2, 0, 0, -1);
    run_instr("reset_in_mwr", 6'd43, 0, 3, 5);
    run_instr("after_abort", 6'd0, 0, 0, -1);
  endtask

  task automatic test_perf();
    test_reset();
    run_instr("perf_r", 6'd0, 0, 0, -1);
    run_instr("perf_lw", 6'd35, 0, 0, -1);
    run_instr("perf_sw", 6'd43, 0, 0, -1);
    run_instr("perf_beq", 6'd4, 0, 0, -1);
    run_instr("perf_ill", 6'd63, 0, 0, -1);
    #4;
    n_cmp++;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    if (instr_cnt_o !== 32'd4) begin
      n_bad++;
      $display("FAIL perf total: got %0d want 4", instr_cnt_o);
    end
`else
    if (instr_cnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL perf total: got %0d want 0", instr_cnt_o);
    end
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};
    logic [5:0] op;
    int unsigned pick;
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 7);
      op = (pick == 7) ? 6'($urandom_range(0, 63)) : ops[pick];
      run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem_wait();
    test_if_stall();
    test_branch_jump();
    test_illegal();
    test_random();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
